// File: rtl/wishbone_slave_regs_pkg.sv
// wishbone_slave_regs_pkg
//   Shared definitions for the wishbone register slave: register map
//   indices, FSM state encoding and the latched request record.
package wishbone_slave_regs_pkg;

  localparam int REG_ID       = 0;
  localparam int REG_CONTROL  = 1;
  localparam int REG_STATUS   = 2;
  localparam int REG_SCRATCH0 = 3;

  localparam int EVT_W = 8;   // event / enable / status width
  localparam int CNT_W = 4;   // wait-state counter, covers 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;

  // Transfer captured when the strobe is accepted in IDLE.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        sel;
  } wb_req_t;

endpackage

// File: rtl/wishbone_slave_regs_regfile.sv
// wb_slave_regfile
//   Register file behind the wishbone slave: ID (RO), CONTROL (RW, 8-bit
//   interrupt enable), STATUS (8-bit, event set / write-1-to-clear) and
//   scratch registers 3..NUM_REGS-1. Out-of-range addresses read 0 and
//   ignore writes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en      commit wdata to addr this edge
//   addr       word address (latched by the bus FSM; used for read too)
//   wdata      write data
//   event_i    event pulses, set STATUS bits
//   rdata      combinational read data for addr
//   int_o      registered |(STATUS & CONTROL)
module wb_slave_regfile
  import wishbone_slave_regs_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'h00001EAF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [EVT_W-1:0] event_i,
  output logic [31:0]      rdata,
  output logic             int_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [EVT_W-1:0] control;
  logic [EVT_W-1:0] status;
  logic [EVT_W-1:0] status_clr;
  logic [31:0]      scratch [REG_SCRATCH0:NUM_REGS-1];

  // Full 32-bit compare so aliases above NUM_REGS never hit a register.
  assign in_range = addr < 32'(NUM_REGS);
  assign idx      = addr[IDX_W-1:0];

  assign status_clr = (wr_en && in_range && idx == IDX_W'(REG_STATUS))
                    ? wdata[EVT_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      control <= '0;
      status  <= '0;
      int_o   <= 1'b0;
    end else begin
      if (wr_en && in_range && idx == IDX_W'(REG_CONTROL))
        control <= wdata[EVT_W-1:0];
      // Set is applied after clear so a same-cycle event wins.
      status <= (status & ~status_clr) | event_i;
      int_o  <= |(status & control);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
      if (rst)
        scratch[i] <= '0;
      else if (wr_en && in_range && idx == IDX_W'(i))
        scratch[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (in_range) begin
      if (idx == IDX_W'(REG_ID))
        rdata = ID_VALUE;
      else if (idx == IDX_W'(REG_CONTROL))
        rdata = {{(32-EVT_W){1'b0}}, control};
      else if (idx == IDX_W'(REG_STATUS))
        rdata = {{(32-EVT_W){1'b0}}, status};
      else
        for (int i = REG_SCRATCH0; i < NUM_REGS; i++)
          if (idx == IDX_W'(i)) rdata = scratch[i];
    end
  end

endmodule

// File: rtl/wishbone_slave_regs.sv
// wishbone_slave_regs
//   Default wishbone slave: accepts single and back-to-back transfers,
//   optionally inserts WAIT_STATES cycles, acks for one cycle and
//   drives a level interrupt from the register file.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   wb_addr_i   word address          wb_dat_i  write data
//   wb_str_i    strobe                wb_cyc_i  cycle active
//   wb_we_i     1=write               wb_sel_i  0 = ack without write
//   wb_msk_i    reserved, ignored
//   wb_dat_o    read data, 0 outside read acks
//   wb_ack_o    one-cycle acknowledge
//   event_i     event pulses          wb_int_o  registered interrupt
module wishbone_slave_regs
  import wishbone_slave_regs_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h00001EAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_str_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic        wb_sel_i,
  input  logic        wb_msk_i,
  output logic        wb_ack_o,
  input  logic [7:0]  event_i,
  output logic        wb_int_o
);

  wb_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  wb_req_t          req;
  logic             start;
  logic             wr_en;
  logic [31:0]      rdata;
  logic             unused_msk;

  assign unused_msk = wb_msk_i;
  assign start      = (state == ST_IDLE) && wb_cyc_i && wb_str_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start)
        req <= '{addr: wb_addr_i, data: wb_dat_i, we: wb_we_i, sel: wb_sel_i};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE:
        if (start) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ST_ACK;
          end else begin
            cnt_nxt   = CNT_W'(WAIT_STATES - 1);
            state_nxt = ST_WAIT;
          end
        end
      ST_WAIT:
        // Master dropping the cycle abandons the transfer silently.
        if (!wb_cyc_i) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          state_nxt = ST_ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gate with rst so a reset landing on the ack cycle neither acks nor writes.
  assign wb_ack_o = (state == ST_ACK) && !rst;
  assign wr_en    = wb_ack_o && req.we && req.sel;
  assign wb_dat_o = (wb_ack_o && !req.we) ? rdata : '0;

  wb_slave_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addr    (req.addr),
    .wdata   (req.data),
    .event_i (event_i),
    .rdata   (rdata),
    .int_o   (wb_int_o)
  );

endmodule

// File: tb/tb_wishbone_slave_regs.sv
module tb_wishbone_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat;
  logic        we, sel, msk;
  logic        cyc0, str0, cyc3, str3;
  logic [7:0]  ev, ev3;
  logic [31:0] dat0, dat3;
  logic        ack0, ack3, int0, int3;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wishbone_slave_regs #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(32'h00001EAF)) dut0 (
    .clk(clk), .rst(rst), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_dat_o(dat0),
    .wb_str_i(str0), .wb_cyc_i(cyc0), .wb_we_i(we), .wb_sel_i(sel), .wb_msk_i(msk),
    .wb_ack_o(ack0), .event_i(ev), .wb_int_o(int0));

  wishbone_slave_regs #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(32'h00001EAF)) dut3 (
    .clk(clk), .rst(rst), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_dat_o(dat3),
    .wb_str_i(str3), .wb_cyc_i(cyc3), .wb_we_i(we), .wb_sel_i(sel), .wb_msk_i(msk),
    .wb_ack_o(ack3), .event_i(ev3), .wb_int_o(int3));

  // One transfer on dut0 (which=0) or dut3 (which=1). lat = cycles from the
  // sampling edge to the ack cycle, -1 if no ack within the budget.
  task automatic xfer(input bit which, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic s,
                      output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    addr = a; wdat = d; we = w; sel = s;
    if (which) begin cyc3 = 1'b1; str3 = 1'b1; end
    else       begin cyc0 = 1'b1; str0 = 1'b1; end
    lat = -1; rd = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (which ? ack3 : ack0) begin
        rd = which ? dat3 : dat0; lat = i; break;
      end
    end
    @(posedge clk); #1;
    cyc0 = 1'b0; str0 = 1'b0; cyc3 = 1'b0; str3 = 1'b0; we = 1'b0; sel = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int lat;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, dat0, int0, ack3, dat3, int3} !== '0) begin
      errors++; $display("FAIL reset_outputs got ack=%b dat=%h int=%b need all 0", ack0, dat0, int0);
    end
    @(posedge clk); #1; rst = 1'b0;
    xfer(0, 1'b0, 32'd0, 32'd0, 1'b0, rd, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL id_latency got %0d need 1", lat); end
    checks++;
    if (rd !== 32'h00001EAF) begin errors++; $display("FAIL id_read got %h need 00001eaf", rd); end
    @(negedge clk);
    checks++;
    if (dat0 !== 32'h0) begin errors++; $display("FAIL dat_idle got %h need 0", dat0); end
  endtask

  task automatic test_scratch;
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 32'd3, 32'hDEADBEEF, 1'b1, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      errors++; $display("FAIL write_ack got lat=%0d dat=%h need lat=1 dat=0", lat, rd);
    end
    xfer(0, 1'b0, 32'd3, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch3_read got %h need deadbeef", rd); end
    xfer(0, 1'b1, 32'd9, 32'h12345678, 1'b1, rd, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL oob_write_ack got %0d need 1", lat); end
    xfer(0, 1'b0, 32'd9, 32'd0, 1'b0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      errors++; $display("FAIL oob_read got lat=%0d dat=%h need lat=1 dat=0", lat, rd);
    end
    xfer(0, 1'b1, 32'd0, 32'h55555555, 1'b1, rd, lat);
    xfer(0, 1'b0, 32'd0, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h00001EAF) begin errors++; $display("FAIL id_ro got %h need 00001eaf", rd); end
    xfer(0, 1'b1, 32'd1, 32'hFFFFFFFF, 1'b1, rd, lat);
    xfer(0, 1'b0, 32'd1, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h000000FF) begin errors++; $display("FAIL control_width got %h need 000000ff", rd); end
    xfer(0, 1'b1, 32'd1, 32'h0, 1'b1, rd, lat);
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; int lat; int seen;
    xfer(1, 1'b1, 32'd5, 32'h00000011, 1'b1, rd, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ws3_write_latency got %0d need 4", lat); end
    xfer(1, 1'b0, 32'd5, 32'd0, 1'b0, rd, lat);
    checks++;
    if (lat !== 4 || rd !== 32'h00000011) begin
      errors++; $display("FAIL ws3_read got lat=%0d dat=%h need lat=4 dat=11", lat, rd);
    end
    // Abort: strobe sampled at T, cycle low when edge T+2 samples it.
    @(posedge clk); #1;
    addr = 32'd5; wdat = 32'h00000022; we = 1'b1; sel = 1'b1; cyc3 = 1'b1; str3 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc3 = 1'b0; str3 = 1'b0; we = 1'b0; sel = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack3) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_ack got %0d acks need 0", seen); end
    xfer(1, 1'b0, 32'd5, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h00000011) begin errors++; $display("FAIL abort_no_write got %h need 11", rd); end
  endtask

  task automatic test_interrupt;
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 32'd1, 32'h00000004, 1'b1, rd, lat);
    @(posedge clk); #1; ev = 8'h05;
    @(posedge clk); #1; ev = 8'h00;
    @(negedge clk);
    checks++;
    if (int0 !== 1'b0) begin errors++; $display("FAIL int_not_early got %b need 0", int0); end
    @(negedge clk);
    checks++;
    if (int0 !== 1'b1) begin errors++; $display("FAIL int_assert got %b need 1", int0); end
    xfer(0, 1'b0, 32'd2, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h00000005) begin errors++; $display("FAIL status_set got %h need 5", rd); end
    xfer(0, 1'b1, 32'd2, 32'h00000004, 1'b1, rd, lat);
    @(negedge clk);
    checks++;
    if (int0 !== 1'b1) begin errors++; $display("FAIL int_hold_one got %b need 1", int0); end
    @(negedge clk);
    checks++;
    if (int0 !== 1'b0) begin errors++; $display("FAIL int_clear got %b need 0", int0); end
    xfer(0, 1'b0, 32'd2, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h00000001) begin errors++; $display("FAIL status_w1c got %h need 1", rd); end
    ev = 8'h01;
    xfer(0, 1'b1, 32'd2, 32'h00000001, 1'b1, rd, lat);
    ev = 8'h00;
    xfer(0, 1'b0, 32'd2, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h00000001) begin errors++; $display("FAIL set_wins got %h need 1", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat; int t [4]; logic [31:0] exp;
    @(posedge clk); #1;
    addr = 32'd3; wdat = 32'd1; we = 1'b1; sel = 1'b1; cyc0 = 1'b1; str0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t[k] = -1;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (ack0) begin t[k] = cyc_cnt; break; end
      end
      @(posedge clk); #1;
      if (k < 3) begin addr = 32'(4 + k); wdat = 32'(k + 2); end
      else begin cyc0 = 1'b0; str0 = 1'b0; we = 1'b0; sel = 1'b0; end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (t[k-1] < 0 || t[k] < 0 || t[k] - t[k-1] != 2) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d need 2", k, t[k] - t[k-1]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b0, 32'(3 + k), 32'd0, 1'b0, rd, lat);
      exp = 32'(k + 1);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL b2b_readback%0d got %h need %h", k, rd, exp); end
    end
  endtask

  task automatic test_sel;
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 32'd4, 32'h0000FFFF, 1'b0, rd, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sel0_ack got %0d need 1", lat); end
    xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL sel0_nowrite got %h need 2", rd); end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdat = '0; we = 1'b0; sel = 1'b0; msk = 1'b0;
    cyc0 = 1'b0; str0 = 1'b0; cyc3 = 1'b0; str3 = 1'b0; ev = '0; ev3 = '0;
    test_reset();
    test_scratch();
    test_wait_states();
    test_interrupt();
    test_back_to_back();
    test_sel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_slave_regs.md
# wishbone_slave_regs

Wishbone responder that completes single and back-to-back transfers issued by the host-side wishbone master, backed by a small register file: ID, control, interrupt status and general-purpose registers. It is the default slave on the bus and the template for peripheral slaves. It drives a level interrupt to the master when an enabled event bit is pending.

## Interface
- NUM_REGS, 8, number of 32-bit registers (4..256)
- WAIT_STATES, 0, extra cycles inserted before ack (0..15)
- ID_VALUE, 32'h00001EAF, constant returned by register 0
- Reset: rst, synchronous, active-high. Clock: clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_addr_i  in  32  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid only while wb_ack_o=1
- wb_str_i  in  1  strobe, transfer request
- wb_cyc_i  in  1  bus cycle active
- wb_we_i  in  1  1=write, 0=read
- wb_sel_i  in  1  write enable qualifier; 0 = acknowledged, no write
- wb_msk_i  in  1  reserved, ignored
- wb_ack_o  out  1  one-cycle transfer acknowledge
- event_i  in  8  event pulses, set status bits
- wb_int_o  out  1  interrupt, registered

## Operation
- Register map (index = wb_addr_i): 0 ID (RO, ID_VALUE); 1 CONTROL (RW, bits[7:0] interrupt enable, bits[31:8] read 0); 2 STATUS (bits[7:0], write-1-to-clear, bits[31:8] read 0); 3..NUM_REGS-1 scratch (RW, full 32 bits).
- Address >= NUM_REGS: read returns 32'h0, write ignored, ack still given (bus never hangs).
- Writes to register 0 ignored, acked.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on wb_cyc_i & wb_str_i, latch addr/we/sel/data; WAIT_STATES=0 -> ACK, else load counter with WAIT_STATES-1 -> WAIT.
  - WAIT: decrement; at 0 -> ACK. wb_cyc_i low -> IDLE (abort).
  - ACK: wb_ack_o=1 one cycle; write committed at the end of this cycle if we & sel; read data presented from latched address. Next state IDLE unconditionally.
- Abort: wb_cyc_i low in WAIT -> no write, no ack.
- STATUS: bit n set on event_i[n]=1; cleared by write with data bit n=1. Same-cycle set and clear -> set wins.
- wb_int_o <= |(STATUS[7:0] & CONTROL[7:0]).

## Timing
- Reset values: wb_dat_o 0, wb_ack_o 0, wb_int_o 0, CONTROL 0, STATUS 0, scratch 0, state IDLE, counter 0.
- Latency: strobe sampled at edge T -> wb_ack_o high in cycle T+1+WAIT_STATES.
- wb_dat_o is 0 outside ack cycles and during write acks.
- Back-to-back: strobe still high at the edge ending ACK is sampled in IDLE one edge later as a new transfer; peak rate is 1 transfer / (2+WAIT_STATES) cycles.
- Register write visible on a read issued at the next strobe.
- Interrupt: event at edge E -> STATUS at E, wb_int_o at E+1.
- rst mid-transfer: ack suppressed, no write, all state reset that edge; rst dominates event_i.

## Structure
- Shared defines header wishbone_slave_defines: REG_ID=0, REG_CONTROL=1, REG_STATUS=2, REG_SCRATCH0=3, FSM encodings IDLE/WAIT/ACK.
- One sub-module: wb_slave_regfile (map decode, RO/W1C/RW handling, event set logic, read mux); FSM and counter in top.

## Test plan
- Reset, then read addr 0 -> ack in cycle T+1, wb_dat_o=32'h00001EAF; all outputs 0 during reset.
- Write 32'hDEADBEEF to addr 3, read addr 3 -> 32'hDEADBEEF; write addr 9 (NUM_REGS=8) acked, read addr 9 -> 32'h0.
- WAIT_STATES=3: strobe at T -> ack exactly in T+4; drop wb_cyc_i at T+2 -> no ack, scratch unchanged.
- event_i=8'h05, CONTROL=8'h04 -> STATUS=8'h05, wb_int_o=1; write STATUS 8'h04 -> STATUS=8'h01, wb_int_o=0 next cycle; event_i[0] with simultaneous clear of bit 0 -> bit 0 stays 1.
- Stream of 4 writes with strobe held high, data 1..4 to addr 3..6 -> 4 acks spaced 2 cycles, readback 1..4.
- Write with wb_sel_i=0 to addr 4 -> acked, addr 4 keeps prior value.
